// File: rtl/ap_cam_engine_if.sv
// Command/response bundle between the AP microcode controller and the CAM engine.
// master = controller side, slave = engine side.
interface ap_cam_engine_if #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned CELL_QUANT = 512
);
    localparam int unsigned ADDR_W = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;
    localparam int unsigned CNT_W  = $clog2(CELL_QUANT + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [WORD_SIZE-1:0]  cmd_key;
    logic [WORD_SIZE-1:0]  cmd_mask;
    logic [WORD_SIZE-1:0]  cmd_data;
    logic [1:0]            tag_mode;
    logic [CELL_QUANT-1:0] tags;
    logic                  rsp_valid;
    logic [WORD_SIZE-1:0]  rsp_data;
    logic [CNT_W-1:0]      rsp_count;
    logic [ADDR_W-1:0]     rsp_first;
    logic                  rsp_hit;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data, tag_mode,
        input  cmd_ready, tags, rsp_valid, rsp_data, rsp_count, rsp_first, rsp_hit
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data, tag_mode,
        output cmd_ready, tags, rsp_valid, rsp_data, rsp_count, rsp_first, rsp_hit
    );
endinterface

// File: rtl/ap_cam_engine.sv
// Sequenced associative-processor CAM: masked write/read/compare, tagged parallel write,
// and a chunked multi-cycle tag scan returning match count and first-match index.
module ap_cam_engine #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned CELL_QUANT = 512,
    parameter int unsigned CHUNK      = 32
) (
    input logic              CLK100MHZ,
    input logic              rst,
    ap_cam_engine_if.slave   cam_io
);
    localparam int unsigned ADDR_W = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;
    localparam int unsigned CNT_W  = $clog2(CELL_QUANT + 1);
    localparam int unsigned NCHUNK = CELL_QUANT / CHUNK;
    localparam int unsigned K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [2:0] OpWrite       = 3'd1;
    localparam logic [2:0] OpRead        = 3'd2;
    localparam logic [2:0] OpCompare     = 3'd3;
    localparam logic [2:0] OpWriteTagged = 3'd4;
    localparam logic [2:0] OpSetTags     = 3'd5;
    localparam logic [2:0] OpScan        = 3'd6;

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    state_e                state_q;
    logic [WORD_SIZE-1:0]  mem_q [CELL_QUANT];
    logic [CELL_QUANT-1:0] tags_q;
    logic [K_W-1:0]        scan_k_q;
    logic [CNT_W-1:0]      scan_cnt_q;
    logic [ADDR_W-1:0]     scan_first_q;
    logic                  scan_found_q;
    logic                  rsp_valid_q;
    logic [WORD_SIZE-1:0]  rsp_data_q;
    logic [CNT_W-1:0]      rsp_count_q;
    logic [ADDR_W-1:0]     rsp_first_q;
    logic                  rsp_hit_q;

    logic [CELL_QUANT-1:0] match;
    logic [CHUNK-1:0]      chunk_tags;
    logic [CNT_W-1:0]      chunk_pop;
    logic [ADDR_W-1:0]     chunk_low;
    logic [ADDR_W-1:0]     chunk_base;
    logic                  accept;
    logic                  addr_ok;

    function automatic logic [WORD_SIZE-1:0] masked_write(input logic [WORD_SIZE-1:0] old_w,
                                                          input logic [WORD_SIZE-1:0] data,
                                                          input logic [WORD_SIZE-1:0] mask);
        return (old_w & ~mask) | (data & mask);
    endfunction

    assign accept  = cam_io.cmd_valid && (state_q == StIdle);
    assign addr_ok = 32'(cam_io.cmd_addr) < CELL_QUANT;

    always_comb begin
        match = '0;
        for (int i = 0; i < int'(CELL_QUANT); i++) begin
            match[i] = ((mem_q[i] ^ cam_io.cmd_key) & cam_io.cmd_mask) == '0;
        end
        chunk_tags = '0;
        for (int c = 0; c < int'(NCHUNK); c++) begin
            if (scan_k_q == K_W'(c)) chunk_tags = tags_q[c*CHUNK +: CHUNK];
        end
        chunk_pop = '0;
        for (int j = 0; j < int'(CHUNK); j++) begin
            chunk_pop = chunk_pop + CNT_W'(chunk_tags[j]);
        end
        // Walk downward so the lowest set offset wins.
        chunk_low = '0;
        for (int j = int'(CHUNK) - 1; j >= 0; j--) begin
            if (chunk_tags[j]) chunk_low = ADDR_W'(j);
        end
        chunk_base = ADDR_W'(32'(scan_k_q) * CHUNK);
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            for (int i = 0; i < int'(CELL_QUANT); i++) mem_q[i] <= '0;
            tags_q       <= '0;
            scan_k_q     <= '0;
            scan_cnt_q   <= '0;
            scan_first_q <= '0;
            scan_found_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_count_q  <= '0;
            rsp_first_q  <= '0;
            rsp_hit_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (cam_io.cmd_op)
                            OpWrite: begin
                                if (addr_ok) begin
                                    mem_q[cam_io.cmd_addr] <= masked_write(
                                        mem_q[cam_io.cmd_addr], cam_io.cmd_data, cam_io.cmd_mask);
                                end
                            end
                            OpRead: begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= addr_ok ? mem_q[cam_io.cmd_addr] : '0;
                            end
                            OpCompare: begin
                                unique case (cam_io.tag_mode)
                                    2'b00: tags_q <= match;
                                    2'b01: tags_q <= tags_q & match;
                                    2'b10: tags_q <= tags_q | match;
                                    2'b11: tags_q <= tags_q & ~match;
                                endcase
                            end
                            OpWriteTagged: begin
                                for (int i = 0; i < int'(CELL_QUANT); i++) begin
                                    if (tags_q[i]) begin
                                        mem_q[i] <= masked_write(mem_q[i], cam_io.cmd_data,
                                                                 cam_io.cmd_mask);
                                    end
                                end
                            end
                            OpSetTags: tags_q <= '1;
                            OpScan: begin
                                state_q      <= StScan;
                                scan_k_q     <= '0;
                                scan_cnt_q   <= '0;
                                scan_first_q <= '0;
                                scan_found_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                StScan: begin
                    scan_cnt_q <= scan_cnt_q + chunk_pop;
                    if (!scan_found_q && (chunk_tags != '0)) begin
                        scan_found_q <= 1'b1;
                        scan_first_q <= chunk_base + chunk_low;
                    end
                    if (scan_k_q == K_W'(NCHUNK - 1)) state_q <= StResp;
                    else                              scan_k_q <= scan_k_q + 1'b1;
                end
                StResp: begin
                    rsp_valid_q <= 1'b1;
                    rsp_count_q <= scan_cnt_q;
                    rsp_first_q <= scan_first_q;
                    rsp_hit_q   <= scan_cnt_q != '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cam_io.cmd_ready = (state_q == StIdle);
    assign cam_io.tags      = tags_q;
    assign cam_io.rsp_valid = rsp_valid_q;
    assign cam_io.rsp_data  = rsp_data_q;
    assign cam_io.rsp_count = rsp_count_q;
    assign cam_io.rsp_first = rsp_first_q;
    assign cam_io.rsp_hit   = rsp_hit_q;
endmodule

// File: tb/tb_ap_cam_engine.sv
// Directed self-checking bench for ap_cam_engine (512 x 8-bit words, 32-tag scan chunks).
module tb_ap_cam_engine;
    localparam int unsigned WS = 8;
    localparam int unsigned CQ = 512;
    localparam int unsigned CH = 32;

    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RD = 3'd2, CMP = 3'd3, WRT = 3'd4,
                           SETT = 3'd5, SCAN = 3'd6;
    localparam logic [1:0] MSET = 2'b00, MAND = 2'b01, MOR = 2'b10, MCLR = 2'b11;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ap_cam_engine_if #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) bus ();

    ap_cam_engine #(.WORD_SIZE(WS), .CELL_QUANT(CQ), .CHUNK(CH)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .cam_io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tags(input string tag, input logic [CQ-1:0] exp);
        checks++;
        assert (bus.tags === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, bus.tags, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [8:0] addr, input logic [7:0] key,
                       input logic [7:0] mask, input logic [7:0] data, input logic [1:0] mode);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_key   = key;
        bus.cmd_mask  = mask;
        bus.cmd_data  = data;
        bus.tag_mode  = mode;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
    endtask

    task automatic read_chk(input string tag, input logic [8:0] addr, input logic [7:0] exp);
        cmd(RD, addr, 8'h00, 8'h00, 8'h00, MSET);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk(tag, 32'(bus.rsp_data), 32'(exp));
    endtask

    // Issues SCAN and waits (bounded) for the response; checks latency and that ready stays low.
    task automatic scan_chk(input string tag, input int exp_cnt, input int exp_first,
                            input logic exp_hit);
        int   lat;
        logic ready_seen;
        lat        = 0;
        ready_seen = 1'b0;
        cmd(SCAN, 9'd0, 8'h00, 8'h00, 8'h00, MSET);
        chk({tag, "_ready_after_accept"}, 32'(bus.cmd_ready), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
            if (bus.cmd_ready) ready_seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd17);
        chk({tag, "_ready_low"}, 32'(ready_seen), 32'd0);
        chk({tag, "_count"}, 32'(bus.rsp_count), 32'(exp_cnt));
        chk({tag, "_first"}, 32'(bus.rsp_first), 32'(exp_first));
        chk({tag, "_hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
        chk({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [CQ-1:0] e;
        logic          vseen;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_addr  = '0;
        bus.cmd_key   = '0;
        bus.cmd_mask  = '0;
        bus.cmd_data  = '0;
        bus.tag_mode  = MSET;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_count", 32'(bus.rsp_count), 32'd0);
        chk_tags("rst_tags", '0);

        // 1: write/read, masked write, hold behaviour
        cmd(WR, 9'd5, 8'h00, 8'hFF, 8'hA5, MSET);
        read_chk("read5", 9'd5, 8'hA5);
        @(posedge clk);
        #1;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_data_hold", 32'(bus.rsp_data), 32'hA5);
        read_chk("read6", 9'd6, 8'h00);
        cmd(WR, 9'd5, 8'h00, 8'h0F, 8'h0F, MSET);
        read_chk("read5_masked", 9'd5, 8'hAF);

        // 2: masked compare SET; mask 0 matches everything
        cmd(WR, 9'd3, 8'h00, 8'hFF, 8'hF0, MSET);
        cmd(CMP, 9'd0, 8'hF0, 8'hF0, 8'h00, MSET);
        e = '0; e[3] = 1'b1;
        chk_tags("cmp_set_f0", e);
        cmd(CMP, 9'd0, 8'h5A, 8'h00, 8'h00, MSET);
        chk_tags("cmp_mask0", '1);

        // 3: OR accumulation, AND narrowing, CLEAR
        cmd(CMP, 9'd0, 8'h00, 8'h00, 8'h00, MCLR);
        chk_tags("cmp_clear_all", '0);
        cmd(WR, 9'd7, 8'h00, 8'hFF, 8'h77, MSET);
        cmd(CMP, 9'd0, 8'hF0, 8'hFF, 8'h00, MOR);
        cmd(CMP, 9'd0, 8'h77, 8'hFF, 8'h00, MOR);
        e = '0; e[3] = 1'b1; e[7] = 1'b1;
        chk_tags("cmp_or_3_7", e);
        cmd(CMP, 9'd0, 8'h77, 8'hFF, 8'h00, MAND);
        e = '0; e[7] = 1'b1;
        chk_tags("cmp_and_7", e);
        cmd(CMP, 9'd0, 8'h77, 8'hFF, 8'h00, MCLR);
        chk_tags("cmp_clear_7", '0);

        // 4: tagged parallel write
        pulse_reset();
        cmd(WR, 9'd2, 8'h00, 8'hFF, 8'hF0, MSET);
        cmd(WR, 9'd300, 8'h00, 8'hFF, 8'hF0, MSET);
        cmd(CMP, 9'd0, 8'hF0, 8'hFF, 8'h00, MSET);
        cmd(WR, 9'd4, 8'h00, 8'hFF, 8'hF0, MSET);
        cmd(WRT, 9'd0, 8'h00, 8'h0F, 8'h0F, MSET);
        e = '0; e[2] = 1'b1; e[300] = 1'b1;
        chk_tags("wrt_tags_kept", e);
        read_chk("wrt_w2", 9'd2, 8'hFF);
        read_chk("wrt_w300", 9'd300, 8'hFF);
        read_chk("wrt_w4", 9'd4, 8'hF0);

        // 5: scans
        pulse_reset();
        cmd(WR, 9'd40, 8'h00, 8'hFF, 8'h11, MSET);
        cmd(WR, 9'd511, 8'h00, 8'hFF, 8'h11, MSET);
        cmd(CMP, 9'd0, 8'h11, 8'hFF, 8'h00, MSET);
        scan_chk("scan_40_511", 2, 40, 1'b1);
        @(posedge clk);
        #1;
        chk("scan_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("scan_count_hold", 32'(bus.rsp_count), 32'd2);
        cmd(CMP, 9'd0, 8'h00, 8'h00, 8'h00, MCLR);
        scan_chk("scan_zero", 0, 0, 1'b0);
        cmd(SETT, 9'd0, 8'h00, 8'h00, 8'h00, MSET);
        scan_chk("scan_all", 512, 0, 1'b1);

        // 6: reset during a scan aborts it
        cmd(SCAN, 9'd0, 8'h00, 8'h00, 8'h00, MSET);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
        chk_tags("abort_tags", '0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        vseen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) vseen = 1'b1;
        end
        chk("abort_no_rsp", 32'(vseen), 32'd0);
        cmd(WR, 9'd100, 8'h00, 8'hFF, 8'h33, MSET);
        cmd(CMP, 9'd0, 8'h33, 8'hFF, 8'h00, MSET);
        scan_chk("scan_after_abort", 1, 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
